lbpe_ctrl: RTL and testbench
============================

Name: lbpe_ctrl

Overview:
- Sequencing controller for one LUT-based PE (4 LUT bundles, bit-serial weights).
- Per job: accepts one activation set, pulses the LUT-rebuild strobe, then streams weight bits MSB-first for each weight group.
- Drives accumulator controls and reports each finished partial sum after the datapath pipeline latency.
- Sits between the tile scheduler (start/done) and the PE datapath plus weight buffer.

Parameters:
WEIGHT_WIDTH, 16, maximum weight precision in bits
GROUP_W, 8, width of weight-group count and address
PIPE_LAT, 2, cycles from a bit issue (acc_en) to the accumulator result; must be >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
cfg_prec  in  5  weight precision, 1..WEIGHT_WIDTH
cfg_groups  in  GROUP_W  number of weight groups per activation set
cfg_mode  in  1  0 = multi-bit, 1 = binary (1-bit) mode
act_valid  in  1  activation set available
act_ready  out  1  controller accepts activation set
lut_load  out  1  new_activation strobe to the LUT bundles
lut_mode  out  1  mode to the LUT bundles (latched cfg_mode)
wt_valid  in  1  weight bit-slice available for the current wt_addr/wt_bit
wt_addr  out  GROUP_W  current weight group
wt_bit  out  4  current bit index
acc_en  out  1  accumulate this cycle (bit issued)
acc_clr  out  1  with acc_en: first bit of group, accumulator starts from 0
acc_neg  out  1  with acc_en: subtract shifted value (two's-complement sign bit)
psum_valid  out  1  partial sum ready
psum_addr  out  GROUP_W  group index of psum_valid
busy  out  1  state != IDLE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; latched config 0; valid pipe cleared. Reset mid-job aborts without any further psum_valid or done.
- On start in IDLE, latch config:
  - prec = clamp(cfg_prec, 1, WEIGHT_WIDTH), forced to 1 when cfg_mode=1.
  - groups = max(cfg_groups, 1).
  - lut_mode = cfg_mode.
- start is ignored while busy.
- States:
  - IDLE: on start -> WAIT_ACT.
  - WAIT_ACT: act_ready=1 (combinational from state); act_valid&act_ready -> LOAD.
  - LOAD: lut_load=1 for exactly 1 cycle -> STREAM with wt_addr=0, wt_bit=prec-1.
  - STREAM:
    - acc_en = wt_valid; cycles with wt_valid=0 are stalls, and wt_addr/wt_bit hold.
    - On an issued bit: acc_clr = (wt_bit==prec-1); acc_neg = (wt_bit==prec-1) & (prec>1) & ~lut_mode.
    - wt_bit decrements per issued bit. After bit 0: wt_addr++ and wt_bit reloads to prec-1.
    - Issuing bit 0 of the last group (groups-1) -> FLUSH.
  - FLUSH: exactly PIPE_LAT cycles -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- Valid pipe:
  - PIPE_LAT-deep shift register of {valid, addr}.
  - Loaded with {1, wt_addr} when bit 0 is issued; otherwise loaded with 0.
  - Advances every cycle; the head drives psum_valid/psum_addr.
  - The last psum_valid coincides with the final FLUSH cycle.
- wt_addr/wt_bit are 0 outside STREAM.
- One-bit jobs (prec=1): every issued bit has acc_clr=1 and yields a psum.
- Total cycles, no stalls (cycle 0 = start, act_valid already high at cycle 1): done asserts at cycle 3 + groups*prec + PIPE_LAT.

Test Plan:
- prec=4, groups=2, mode=0, act_valid high, wt_valid high, start@0 -> act_ready@1, lut_load@2, acc_en cycles 3-10, acc_clr&acc_neg @3 and @7, psum_valid addr0 @8 and addr1 @12, done @13.
- mode=1, cfg_prec=7, groups=3 -> prec forced to 1; acc_clr every issued bit, acc_neg never; psums addr 0,1,2 at cycles 5,6,7; done @8.
- Same as the first scenario but wt_valid=0 at cycles 4-5 -> wt_bit holds at 2; acc_en low at 4-5; every later event shifted by +2; done @15.
- Edge config: cfg_prec=0 / cfg_prec=20 / cfg_groups=0 -> behave as prec=1 / prec=16 / groups=1; exactly one psum_valid when groups=0.
- act_valid delayed until cycle 6 -> stays in WAIT_ACT; act_ready high cycles 1-6; lut_load @7. A start pulse during busy has no effect.
- rst asserted in STREAM (cycle 6 of the first scenario) -> next cycle: busy=0, all outputs 0; no psum_valid or done follows; a new start runs normally.

Source files
------------

// File: rtl/lbpe_ctrl.sv
// Sequencing controller for one LUT-based PE: accepts an activation set,
// strobes the LUT rebuild, streams weight bits MSB-first per group, drives
// the accumulator controls and reports finished partial sums after the
// datapath latency.
module lbpe_ctrl #(
    parameter int unsigned WEIGHT_WIDTH = 16,  // <= 16 so that wt_bit fits in 4 bits
    parameter int unsigned GROUP_W      = 8,
    parameter int unsigned PIPE_LAT     = 2    // >= 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         cfg_prec,
    input  logic [GROUP_W-1:0] cfg_groups,
    input  logic               cfg_mode,
    input  logic               act_valid,
    output logic               act_ready,
    output logic               lut_load,
    output logic               lut_mode,
    input  logic               wt_valid,
    output logic [GROUP_W-1:0] wt_addr,
    output logic [3:0]         wt_bit,
    output logic               acc_en,
    output logic               acc_clr,
    output logic               acc_neg,
    output logic               psum_valid,
    output logic [GROUP_W-1:0] psum_addr,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PREC_W  = 5;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FLUSH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [PREC_W-1:0]  PREC_MAX   = PREC_W'(WEIGHT_WIDTH);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACT,
        S_LOAD,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic [PREC_W-1:0]               prec_q, prec_d;
    logic [GROUP_W-1:0]              groups_q, groups_d;
    logic                            mode_q, mode_d;
    logic [GROUP_W-1:0]              addr_q, addr_d;
    logic [BIT_W-1:0]                bit_q, bit_d;
    logic [FLUSH_W-1:0]              flush_q, flush_d;
    logic [PIPE_LAT-1:0]             pv_q, pv_d;
    logic [PIPE_LAT-1:0][GROUP_W-1:0] pa_q, pa_d;

    logic first_bit;
    logic last_bit;
    logic last_grp;
    logic group_end;

    // Next-state, config latch, bit/group sequencing and valid-pipe shift.
    always_comb begin
        state_d   = state_q;
        prec_d    = prec_q;
        groups_d  = groups_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        bit_d     = bit_q;
        flush_d   = flush_q;
        act_ready = 1'b0;
        lut_load  = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        acc_neg   = 1'b0;
        done      = 1'b0;
        group_end = 1'b0;

        first_bit = ({1'b0, bit_q} == (prec_q - PREC_W'(1)));
        last_bit  = (bit_q == BIT_W'(0));
        last_grp  = (addr_q == (groups_q - GROUP_W'(1)));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_mode || (cfg_prec == PREC_W'(0))) begin
                        prec_d = PREC_W'(1);
                    end else if (cfg_prec > PREC_MAX) begin
                        prec_d = PREC_MAX;
                    end else begin
                        prec_d = cfg_prec;
                    end
                    groups_d = (cfg_groups == GROUP_W'(0)) ? GROUP_W'(1) : cfg_groups;
                    mode_d   = cfg_mode;
                    state_d  = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                lut_load = 1'b1;
                addr_d   = GROUP_W'(0);
                bit_d    = BIT_W'(prec_q - PREC_W'(1));
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                if (wt_valid) begin
                    acc_en  = 1'b1;
                    acc_clr = first_bit;
                    acc_neg = first_bit && (prec_q > PREC_W'(1)) && !mode_q;
                    if (last_bit) begin
                        group_end = 1'b1;
                        if (last_grp) begin
                            addr_d  = GROUP_W'(0);
                            bit_d   = BIT_W'(0);
                            flush_d = FLUSH_W'(0);
                            state_d = S_FLUSH;
                        end else begin
                            addr_d = addr_q + GROUP_W'(1);
                            bit_d  = BIT_W'(prec_q - PREC_W'(1));
                        end
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pv_d    = '0;
        pa_d    = '0;
        pv_d[0] = group_end;
        pa_d[0] = group_end ? addr_q : GROUP_W'(0);
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
        end
    end

    // State and datapath-control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prec_q   <= '0;
            groups_q <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            bit_q    <= '0;
            flush_q  <= '0;
            pv_q     <= '0;
            pa_q     <= '0;
        end else begin
            state_q  <= state_d;
            prec_q   <= prec_d;
            groups_q <= groups_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            bit_q    <= bit_d;
            flush_q  <= flush_d;
            pv_q     <= pv_d;
            pa_q     <= pa_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign lut_mode   = mode_q;
    assign wt_addr    = addr_q;
    assign wt_bit     = bit_q;
    assign psum_valid = pv_q[PIPE_LAT-1];
    assign psum_addr  = pa_q[PIPE_LAT-1];

endmodule

// File: tb/tb_lbpe_ctrl.sv
// Self-checking bench for lbpe_ctrl: directed scenarios plus randomized jobs
// compared cycle by cycle against a schedule derived from the job rules.
module tb_lbpe_ctrl;

    localparam int WW   = 16;
    localparam int GW   = 8;
    localparam int PL   = 2;
    localparam int MAXC = 512;

    logic          clk;
    logic          rst;
    logic          start;
    logic [4:0]    cfg_prec;
    logic [GW-1:0] cfg_groups;
    logic          cfg_mode;
    logic          act_valid;
    logic          act_ready;
    logic          lut_load;
    logic          lut_mode;
    logic          wt_valid;
    logic [GW-1:0] wt_addr;
    logic [3:0]    wt_bit;
    logic          acc_en;
    logic          acc_clr;
    logic          acc_neg;
    logic          psum_valid;
    logic [GW-1:0] psum_addr;
    logic          busy;
    logic          done;

    lbpe_ctrl #(
        .WEIGHT_WIDTH(WW),
        .GROUP_W     (GW),
        .PIPE_LAT    (PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_prec  (cfg_prec),
        .cfg_groups(cfg_groups),
        .cfg_mode  (cfg_mode),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .lut_load  (lut_load),
        .lut_mode  (lut_mode),
        .wt_valid  (wt_valid),
        .wt_addr   (wt_addr),
        .wt_bit    (wt_bit),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .acc_neg   (acc_neg),
        .psum_valid(psum_valid),
        .psum_addr (psum_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs of one job, and its stimulus.
    bit         e_busy  [MAXC];
    bit         e_ar    [MAXC];
    bit         e_ll    [MAXC];
    bit         e_lm    [MAXC];
    bit         e_en    [MAXC];
    bit         e_clr   [MAXC];
    bit         e_neg   [MAXC];
    bit         e_psv   [MAXC];
    bit         e_done  [MAXC];
    logic [7:0] e_addr  [MAXC];
    logic [3:0] e_bit   [MAXC];
    logic [7:0] e_psa   [MAXC];
    bit         s_act   [MAXC];
    bit         s_wt    [MAXC];
    bit         s_start [MAXC];
    bit         cur_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        check("busy",       32'(busy),       32'(e_busy[c]));
        check("act_ready",  32'(act_ready),  32'(e_ar[c]));
        check("lut_load",   32'(lut_load),   32'(e_ll[c]));
        check("lut_mode",   32'(lut_mode),   32'(e_lm[c]));
        check("wt_addr",    32'(wt_addr),    32'(e_addr[c]));
        check("wt_bit",     32'(wt_bit),     32'(e_bit[c]));
        check("acc_en",     32'(acc_en),     32'(e_en[c]));
        check("acc_clr",    32'(acc_clr),    32'(e_clr[c]));
        check("acc_neg",    32'(acc_neg),    32'(e_neg[c]));
        check("psum_valid", 32'(psum_valid), 32'(e_psv[c]));
        check("psum_addr",  32'(psum_addr),  32'(e_psa[c]));
        check("done",       32'(done),       32'(e_done[c]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(busy),       32'(0));
        check({tag, "_ar"},    32'(act_ready),  32'(0));
        check({tag, "_ll"},    32'(lut_load),   32'(0));
        check({tag, "_lm"},    32'(lut_mode),   32'(0));
        check({tag, "_addr"},  32'(wt_addr),    32'(0));
        check({tag, "_bit"},   32'(wt_bit),     32'(0));
        check({tag, "_en"},    32'(acc_en),     32'(0));
        check({tag, "_clr"},   32'(acc_clr),    32'(0));
        check({tag, "_neg"},   32'(acc_neg),    32'(0));
        check({tag, "_psv"},   32'(psum_valid), 32'(0));
        check({tag, "_psa"},   32'(psum_addr),  32'(0));
        check({tag, "_done"},  32'(done),       32'(0));
    endtask

    // Builds the job schedule from the rules, then drives and checks it.
    task automatic run_job(input int p, input int g, input bit m, input bit rnd,
                           input int act_at, input int st_lo, input int st_hi,
                           input int rst_at, output int done_at, output int npsum);
        int pe, ge, a, k, c, dc, last;
        pe = m ? 1 : ((p == 0) ? 1 : ((p > WW) ? WW : p));
        ge = (g == 0) ? 1 : g;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_ar[i] = 0; e_ll[i] = 0; e_lm[i] = m;
            e_en[i] = 0; e_clr[i] = 0; e_neg[i] = 0; e_psv[i] = 0; e_done[i] = 0;
            e_addr[i] = '0; e_bit[i] = '0; e_psa[i] = '0;
            s_act[i]   = rnd ? (($urandom_range(0, 3) == 0) || (i >= 9)) : (i >= act_at);
            s_wt[i]    = rnd ? ((i > 300) || ($urandom_range(0, 9) < 7))
                             : !((i >= st_lo) && (i <= st_hi));
            s_start[i] = (i > 0) && ($urandom_range(0, 4) == 0);
        end
        e_lm[0] = cur_mode;
        a = 1;
        while (!s_act[a]) a++;
        for (int i = 1; i <= a; i++) e_ar[i] = 1;
        e_ll[a+1] = 1;
        k = 0;
        c = a + 2;
        while (k < pe * ge) begin
            e_addr[c] = 8'(k / pe);
            e_bit[c]  = 4'(pe - 1 - (k % pe));
            if (s_wt[c]) begin
                e_en[c]  = 1;
                e_clr[c] = ((k % pe) == 0);
                e_neg[c] = ((k % pe) == 0) && (pe > 1) && !m;
                if ((k % pe) == pe - 1) begin
                    e_psv[c+PL] = 1;
                    e_psa[c+PL] = 8'(k / pe);
                end
                k++;
            end
            c++;
        end
        dc = c - 1 + PL + 1;
        for (int i = 1; i <= dc; i++) e_busy[i] = 1;
        e_done[dc] = 1;
        if (rst_at > dc) rst_at = -1;
        last = (rst_at >= 0) ? rst_at : dc;
        done_at = -1;
        npsum = 0;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            rst        = (i == rst_at);
            start      = (i == 0) ? 1'b1 : s_start[i];
            cfg_prec   = (i == 0) ? 5'(p)  : 5'($urandom);
            cfg_groups = (i == 0) ? 8'(g)  : 8'($urandom_range(0, 7));
            cfg_mode   = (i == 0) ? m      : 1'($urandom);
            act_valid  = s_act[i];
            wt_valid   = s_wt[i];
            #1;
            check_cycle(i);
            if (done) done_at = i;
            if (psum_valid) npsum++;
        end
        cur_mode = m;
        if (rst_at >= 0) begin
            cur_mode = 0;
            for (int j = 0; j < PL + 4; j++) begin
                @(negedge clk);
                rst       = 1'b0;
                start     = 1'b0;
                act_valid = 1'b1;
                wt_valid  = 1'b1;
                #1;
                check_zero("after_rst");
                if (psum_valid) npsum++;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int d, n, p, g, ra;
        bit m;
        rst = 1'b1; start = 1'b0; cfg_prec = '0; cfg_groups = '0; cfg_mode = 1'b0;
        act_valid = 1'b0; wt_valid = 1'b0;
        cur_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");

        run_job(4, 2, 0, 0, 1, -1, -1, -1, d, n);
        check("s1_done_cycle", 32'(d), 32'(13));
        check("s1_psums", 32'(n), 32'(2));
        run_job(7, 3, 1, 0, 1, -1, -1, -1, d, n);
        check("bin_done_cycle", 32'(d), 32'(8));
        check("bin_psums", 32'(n), 32'(3));
        run_job(4, 2, 0, 0, 1, 4, 5, -1, d, n);
        check("stall_done_cycle", 32'(d), 32'(15));
        check("stall_psums", 32'(n), 32'(2));
        run_job(0, 2, 0, 0, 1, -1, -1, -1, d, n);
        check("prec0_done_cycle", 32'(d), 32'(7));
        run_job(20, 1, 0, 0, 1, -1, -1, -1, d, n);
        check("prec20_done_cycle", 32'(d), 32'(21));
        run_job(4, 0, 0, 0, 1, -1, -1, -1, d, n);
        check("grp0_done_cycle", 32'(d), 32'(9));
        check("grp0_psums", 32'(n), 32'(1));
        run_job(4, 2, 0, 0, 6, -1, -1, -1, d, n);
        check("actdly_done_cycle", 32'(d), 32'(18));
        run_job(4, 2, 0, 0, 1, -1, -1, 6, d, n);
        check("rst_no_done", 32'(d), 32'hFFFF_FFFF);
        check("rst_no_psum", 32'(n), 32'(0));
        run_job(4, 2, 0, 0, 1, -1, -1, -1, d, n);
        check("post_rst_done_cycle", 32'(d), 32'(13));

        for (int t = 0; t < 40; t++) begin
            p  = $urandom_range(0, 20);
            g  = $urandom_range(0, 5);
            m  = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 30) : -1;
            run_job(p, g, m, 1, 1, -1, -1, ra, d, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
